// File: rtl/neureka_infeat_buffer_ctrl_pkg.sv
// Shared types and sizing constants for the NEUREKA input-feature buffer and
// its controller.
package neureka_infeat_buffer_ctrl_pkg;

  localparam int unsigned NEUREKA_INFEAT_BUFFER_SIZE_W = 8;
  localparam int unsigned NEUREKA_PE_W                 = 6;
  localparam int unsigned IB_NW = NEUREKA_INFEAT_BUFFER_SIZE_W * NEUREKA_INFEAT_BUFFER_SIZE_W;
  localparam int unsigned IB_LW = $clog2(IB_NW) + 1;

  typedef enum logic [1:0] {
    IB_IDLE,
    IB_LOAD,
    IB_EXTRACT
  } state_infeat_buffer_t;

  typedef enum logic [2:0] {
    IBC_IDLE,
    IBC_CFG,
    IBC_LOAD,
    IBC_EXTRACT,
    IBC_RELEASE,
    IBC_DONE
  } state_infeat_buffer_ctrl_t;

  typedef struct packed {
    logic              goto_load;
    logic              goto_extract;
    logic              goto_idle;
    logic [IB_LW-1:0]  load_len;
    logic [IB_NW-1:0]  enable_implicit_padding;
    logic [IB_NW-1:0]  enable_explicit_padding;
    logic [7:0]        explicit_padding_value_lo;
    logic [7:0]        explicit_padding_value_hi;
    logic              filter_mode;
  } ctrl_infeat_buffer_t;

endpackage

// File: rtl/neureka_infeat_pad_mask.sv
// Combinational per-word implicit/explicit padding mask generator for a
// BUF_W x BUF_W input-feature buffer (word i = r*BUF_W + c).
module neureka_infeat_pad_mask
  import neureka_infeat_buffer_ctrl_pkg::*;
#(
  parameter  int unsigned BUF_W = NEUREKA_INFEAT_BUFFER_SIZE_W,
  localparam int unsigned NW    = BUF_W * BUF_W
) (
  input  logic          filter_mode_i,
  input  logic [1:0]    pad_top_i,
  input  logic [1:0]    pad_bottom_i,
  input  logic [1:0]    pad_left_i,
  input  logic [1:0]    pad_right_i,
  input  logic [3:0]    valid_h_i,
  input  logic [3:0]    valid_w_i,
  output logic [NW-1:0] implicit_o,
  output logic [NW-1:0] explicit_o
);

  logic imp;
  logic border;

  always_comb begin
    implicit_o = '0;
    explicit_o = '0;
    imp        = 1'b0;
    border     = 1'b0;
    for (int unsigned r = 0; r < BUF_W; r++) begin
      for (int unsigned c = 0; c < BUF_W; c++) begin
        imp = (r >= int'(valid_h_i)) || (c >= int'(valid_w_i));
        // bottom/right bounds written as sums to avoid unsigned underflow
        border = (r < int'(pad_top_i)) || (r + int'(pad_bottom_i) >= BUF_W) ||
                 (c < int'(pad_left_i)) || (c + int'(pad_right_i) >= BUF_W);
        implicit_o[r*BUF_W + c] = imp;
        explicit_o[r*BUF_W + c] = border && !imp && !filter_mode_i;
      end
    end
  end

endmodule

// File: rtl/neureka_infeat_buffer_ctrl.sv
// Per-tile sequencer for the input-feature buffer: latches the spatial config,
// registers the padding masks and walks the buffer through load/extract/idle.
module neureka_infeat_buffer_ctrl
  import neureka_infeat_buffer_ctrl_pkg::*;
#(
  parameter  int unsigned BUF_W = NEUREKA_INFEAT_BUFFER_SIZE_W,
  parameter  int unsigned PE_W  = NEUREKA_PE_W,
  localparam int unsigned NW    = BUF_W * BUF_W,
  localparam int unsigned LW    = $clog2(NW) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic                 reuse_i,
  input  logic                 filter_mode_i,
  input  logic [1:0]           pad_top_i,
  input  logic [1:0]           pad_bottom_i,
  input  logic [1:0]           pad_left_i,
  input  logic [1:0]           pad_right_i,
  input  logic [15:0]          pad_value_i,
  input  logic [3:0]           valid_h_i,
  input  logic [3:0]           valid_w_i,
  input  logic [7:0]           n_extract_i,
  input  logic                 extract_done_i,
  input  state_infeat_buffer_t ib_state_i,
  output logic                 goto_load_o,
  output logic                 goto_extract_o,
  output logic                 goto_idle_o,
  output logic [LW-1:0]        load_len_o,
  output logic [NW-1:0]        enable_implicit_padding_o,
  output logic [NW-1:0]        enable_explicit_padding_o,
  output logic [7:0]           explicit_padding_value_lo_o,
  output logic [7:0]           explicit_padding_value_hi_o,
  output logic                 filter_mode_o,
  output logic                 busy_o,
  output logic                 done_o
);

  state_infeat_buffer_ctrl_t state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  n_tgt;

  logic        reuse_q, mode_q;
  logic [1:0]  pt_q, pb_q, pl_q, pr_q;
  logic [15:0] pv_q;
  logic [3:0]  vh_q, vw_q;
  logic [7:0]  next_q;

  logic [NW-1:0] imp_w, exp_w;

  neureka_infeat_pad_mask #(
    .BUF_W (BUF_W)
  ) i_pad_mask (
    .filter_mode_i (mode_q),
    .pad_top_i     (pt_q),
    .pad_bottom_i  (pb_q),
    .pad_left_i    (pl_q),
    .pad_right_i   (pr_q),
    .valid_h_i     (vh_q),
    .valid_w_i     (vw_q),
    .implicit_o    (imp_w),
    .explicit_o    (exp_w)
  );

  assign n_tgt  = (next_q == '0) ? 8'd1 : next_q;
  assign busy_o = (state_q != IBC_IDLE);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    goto_load_o    = 1'b0;
    goto_extract_o = 1'b0;
    goto_idle_o    = 1'b0;
    done_o         = 1'b0;
    case (state_q)
      IBC_IDLE: if (start_i) state_d = IBC_CFG;
      IBC_CFG:  state_d = reuse_q ? IBC_EXTRACT : IBC_LOAD;
      IBC_LOAD: begin
        goto_load_o = (ib_state_i == IB_IDLE);
        if (ib_state_i == IB_EXTRACT) state_d = IBC_EXTRACT;
      end
      IBC_EXTRACT: begin
        goto_extract_o = reuse_q && (ib_state_i != IB_EXTRACT);
        // pass pulses only count once the buffer is actually extracting
        if (extract_done_i && (ib_state_i == IB_EXTRACT)) begin
          if (cnt_q == n_tgt - 8'd1) begin
            cnt_d   = '0;
            state_d = IBC_RELEASE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      IBC_RELEASE: begin
        goto_idle_o = (ib_state_i != IB_IDLE);
        if (ib_state_i == IB_IDLE) state_d = IBC_DONE;
      end
      IBC_DONE: begin
        done_o  = 1'b1;
        state_d = IBC_IDLE;
      end
      default: state_d = IBC_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q                     <= IBC_IDLE;
      cnt_q                       <= '0;
      reuse_q                     <= 1'b0;
      mode_q                      <= 1'b0;
      pt_q                        <= '0;
      pb_q                        <= '0;
      pl_q                        <= '0;
      pr_q                        <= '0;
      pv_q                        <= '0;
      vh_q                        <= '0;
      vw_q                        <= '0;
      next_q                      <= '0;
      load_len_o                  <= '0;
      enable_implicit_padding_o   <= '0;
      enable_explicit_padding_o   <= '0;
      explicit_padding_value_lo_o <= '0;
      explicit_padding_value_hi_o <= '0;
      filter_mode_o               <= 1'b0;
    end else if (enable_i) begin
      if (clear_i) begin
        state_q                     <= IBC_IDLE;
        cnt_q                       <= '0;
        reuse_q                     <= 1'b0;
        mode_q                      <= 1'b0;
        pt_q                        <= '0;
        pb_q                        <= '0;
        pl_q                        <= '0;
        pr_q                        <= '0;
        pv_q                        <= '0;
        vh_q                        <= '0;
        vw_q                        <= '0;
        next_q                      <= '0;
        load_len_o                  <= '0;
        enable_implicit_padding_o   <= '0;
        enable_explicit_padding_o   <= '0;
        explicit_padding_value_lo_o <= '0;
        explicit_padding_value_hi_o <= '0;
        filter_mode_o               <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        if (state_q == IBC_IDLE && start_i) begin
          reuse_q <= reuse_i;
          mode_q  <= filter_mode_i;
          pt_q    <= pad_top_i;
          pb_q    <= pad_bottom_i;
          pl_q    <= pad_left_i;
          pr_q    <= pad_right_i;
          pv_q    <= pad_value_i;
          vh_q    <= valid_h_i;
          vw_q    <= valid_w_i;
          next_q  <= n_extract_i;
        end
        if (state_q == IBC_CFG) begin
          load_len_o                  <= mode_q ? LW'(PE_W * PE_W) : LW'(NW);
          enable_implicit_padding_o   <= imp_w;
          enable_explicit_padding_o   <= exp_w;
          explicit_padding_value_lo_o <= pv_q[7:0];
          explicit_padding_value_hi_o <= pv_q[15:8];
          filter_mode_o               <= mode_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_neureka_infeat_buffer_ctrl.sv
// Directed bench for neureka_infeat_buffer_ctrl; the buffer side (ib_state_i,
// extract_done_i) is driven by hand from each test sequence.
module tb_neureka_infeat_buffer_ctrl;
  import neureka_infeat_buffer_ctrl_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 enable_i, clear_i, start_i, reuse_i, filter_mode_i;
  logic [1:0]           pad_top_i, pad_bottom_i, pad_left_i, pad_right_i;
  logic [15:0]          pad_value_i;
  logic [3:0]           valid_h_i, valid_w_i;
  logic [7:0]           n_extract_i;
  logic                 extract_done_i;
  state_infeat_buffer_t ib_state_i;
  logic                 goto_load_o, goto_extract_o, goto_idle_o;
  logic [6:0]           load_len_o;
  logic [63:0]          imp_o, exp_o;
  logic [7:0]           lo_o, hi_o;
  logic                 filter_mode_o, busy_o, done_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk_i = ~clk_i;

  neureka_infeat_buffer_ctrl #(
    .BUF_W (8),
    .PE_W  (6)
  ) dut (
    .clk_i                       (clk_i),
    .rst_ni                      (rst_ni),
    .enable_i                    (enable_i),
    .clear_i                     (clear_i),
    .start_i                     (start_i),
    .reuse_i                     (reuse_i),
    .filter_mode_i               (filter_mode_i),
    .pad_top_i                   (pad_top_i),
    .pad_bottom_i                (pad_bottom_i),
    .pad_left_i                  (pad_left_i),
    .pad_right_i                 (pad_right_i),
    .pad_value_i                 (pad_value_i),
    .valid_h_i                   (valid_h_i),
    .valid_w_i                   (valid_w_i),
    .n_extract_i                 (n_extract_i),
    .extract_done_i              (extract_done_i),
    .ib_state_i                  (ib_state_i),
    .goto_load_o                 (goto_load_o),
    .goto_extract_o              (goto_extract_o),
    .goto_idle_o                 (goto_idle_o),
    .load_len_o                  (load_len_o),
    .enable_implicit_padding_o   (imp_o),
    .enable_explicit_padding_o   (exp_o),
    .explicit_padding_value_lo_o (lo_o),
    .explicit_padding_value_hi_o (hi_o),
    .filter_mode_o               (filter_mode_o),
    .busy_o                      (busy_o),
    .done_o                      (done_o)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic set_cfg(input logic mode, input logic [1:0] pt, input logic [1:0] pb,
                         input logic [1:0] pl, input logic [1:0] pr, input logic [15:0] pv,
                         input logic [3:0] vh, input logic [3:0] vw, input logic [7:0] n,
                         input logic reuse);
    filter_mode_i = mode;
    pad_top_i = pt; pad_bottom_i = pb; pad_left_i = pl; pad_right_i = pr;
    pad_value_i = pv; valid_h_i = vh; valid_w_i = vw;
    n_extract_i = n; reuse_i = reuse;
  endtask

  // Full tile handshake; called at a negedge with the DUT idle and ib_state_i=IB_IDLE.
  task automatic run_tile(input logic reuse, input int unsigned passes, input logic poke,
                          input logic [63:0] e_imp, input logic [63:0] e_exp,
                          input logic [6:0] e_len, input logic [15:0] e_pv,
                          input logic e_mode, input logic [6:0] prev_len);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("cfg_busy", busy_o, 1);
    check("cfg_no_cmd", {goto_load_o, goto_extract_o, goto_idle_o}, 0);
    check("cfg_len_held", load_len_o, prev_len);
    tick();
    check("masks_imp", imp_o, e_imp);
    check("masks_exp", exp_o, e_exp);
    check("load_len", load_len_o, e_len);
    check("pad_lo", lo_o, e_pv[7:0]);
    check("pad_hi", hi_o, e_pv[15:8]);
    check("fmode", filter_mode_o, e_mode);
    if (!reuse) begin
      check("goto_load_hi", goto_load_o, 1);
      check("no_goto_extract", goto_extract_o, 0);
      ib_state_i = IB_LOAD;
      extract_done_i = 1'b1;
      if (poke) begin
        start_i = 1'b1;
        filter_mode_i = ~filter_mode_i;
      end
      tick();
      extract_done_i = 1'b0;
      start_i = 1'b0;
      check("goto_load_lo", goto_load_o, 0);
      check("load_busy", busy_o, 1);
      if (poke) check("poke_len_kept", load_len_o, e_len);
      ib_state_i = IB_EXTRACT;
      tick();
    end else begin
      check("reuse_no_load", goto_load_o, 0);
      check("goto_extract_hi", goto_extract_o, 1);
      tick();
      check("goto_extract_held", goto_extract_o, 1);
      ib_state_i = IB_EXTRACT;
      tick();
      check("goto_extract_lo", goto_extract_o, 0);
      check("reuse_no_load2", goto_load_o, 0);
    end
    for (int unsigned p = 1; p <= passes; p++) begin
      extract_done_i = 1'b1;
      tick();
      extract_done_i = 1'b0;
      if (p < passes) begin
        check("pass_no_release", goto_idle_o, 0);
        tick();
        check("pass_gap_no_release", goto_idle_o, 0);
      end else begin
        check("release_goto_idle", goto_idle_o, 1);
      end
    end
    tick();
    check("release_held", goto_idle_o, 1);
    check("no_early_done", done_o, 0);
    ib_state_i = IB_IDLE;
    tick();
    check("done_pulse", done_o, 1);
    check("done_no_cmd", goto_idle_o, 0);
    tick();
    check("done_once", done_o, 0);
    check("idle_busy", busy_o, 0);
  endtask

  initial begin
    enable_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; extract_done_i = 1'b0;
    ib_state_i = IB_IDLE;
    set_cfg(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 16'h0000, 4'd8, 4'd8, 8'd1, 1'b0);
    tick();
    tick();
    check("rst_busy", busy_o, 0);
    check("rst_cmds", {goto_load_o, goto_extract_o, goto_idle_o, done_o}, 0);
    check("rst_len", load_len_o, 0);
    check("rst_imp", imp_o, 0);
    check("rst_exp", exp_o, 0);
    check("rst_pv_fm", {lo_o, hi_o, filter_mode_o}, 0);
    rst_ni = 1'b1;
    tick();

    // 3x3, no pad, full tile, one pass; start pulsed mid-tile is ignored
    run_tile(1'b0, 1, 1'b1, 64'h0, 64'h0, 7'd64, 16'h0000, 1'b0, 7'd0);

    // 3x3, top/left pad, 5 valid rows, two passes
    set_cfg(1'b0, 2'd1, 2'd0, 2'd1, 2'd0, 16'h1234, 4'd5, 4'd8, 8'd2, 1'b0);
    run_tile(1'b0, 2, 1'b0, 64'hFFFFFF00_00000000, 64'h00000001_010101FF,
             7'd64, 16'h1234, 1'b0, 7'd64);

    // 1x1, 6x6 valid, pads ignored
    set_cfg(1'b1, 2'd3, 2'd3, 2'd3, 2'd3, 16'hABCD, 4'd6, 4'd6, 8'd1, 1'b0);
    run_tile(1'b0, 1, 1'b0, 64'hFFFFC0C0_C0C0C0C0, 64'h0, 7'd36, 16'hABCD, 1'b1, 7'd64);

    // reuse, three passes
    set_cfg(1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 16'h00FF, 4'd8, 4'd8, 8'd3, 1'b1);
    run_tile(1'b1, 3, 1'b0, 64'h0, 64'h0, 7'd64, 16'h00FF, 1'b0, 7'd36);

    // n_extract=0 behaves as one pass; valid_h=0 marks every word implicit
    set_cfg(1'b0, 2'd2, 2'd2, 2'd2, 2'd2, 16'h8001, 4'd0, 4'd8, 8'd0, 1'b0);
    run_tile(1'b0, 1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 7'd64, 16'h8001, 1'b0, 7'd64);

    // clear while LOAD with the buffer stuck in IB_IDLE
    set_cfg(1'b0, 2'd1, 2'd0, 2'd1, 2'd0, 16'h1234, 4'd5, 4'd8, 8'd1, 1'b0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    check("clr_pre_load", goto_load_o, 1);
    tick();
    check("clr_load_held", goto_load_o, 1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("clr_busy", busy_o, 0);
    check("clr_cmds", {goto_load_o, goto_extract_o, goto_idle_o, done_o}, 0);
    check("clr_len", load_len_o, 0);
    check("clr_imp", imp_o, 0);
    check("clr_exp", exp_o, 0);
    check("clr_pv_fm", {lo_o, hi_o, filter_mode_o}, 0);
    tick();
    check("clr_stays_idle", {busy_o, goto_load_o}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
